// File: rtl/fpcvt_seq_ctrl_if.sv
// Sample-in / packed-float-out handshake bundle for fpcvt_seq_ctrl.
// Each side transfers on a rising edge where valid && ready; valid holds its payload until that edge.
interface fpcvt_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        out_valid;
    logic        out_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;

    modport master (
        output in_valid, D, out_ready,
        input  in_ready, out_valid, S, E, F
    );

    modport slave (
        input  in_valid, D, out_ready,
        output in_ready, out_valid, S, E, F
    );
endinterface

// File: rtl/fpcvt_seq_ctrl.sv
// Multi-cycle 12-bit two's-complement to {S,E[2:0],F[3:0]} float converter (value = F * 2^E).
// Define FPCVT_STATS_EN to add conv_cnt/sat_cnt conversion statistics outputs.
module fpcvt_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    fpcvt_seq_ctrl_if.slave  bus,
    output logic             busy,
`ifdef FPCVT_STATS_EN
    output logic [7:0]       conv_cnt,
    output logic [7:0]       sat_cnt,
`endif
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAG   = 3'd1,
        NORM  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [11:0] d_r;
    logic [11:0] m;
    logic [11:0] abs_d;
    logic [2:0]  e;
    logic [3:0]  f_raw;
    logic        fifth;
    logic        sign_r;
    logic [2:0]  round_e;
    logic [3:0]  round_f;

    assign dbg_state = state;

    // 0x800 has no positive 12-bit counterpart, so its magnitude clamps to 0x7FF.
    always_comb begin
        abs_d = d_r;
        if (d_r[11]) begin
            abs_d = (d_r == 12'h800) ? 12'h7FF : (~d_r + 12'd1);
        end
    end

    always_comb begin
        round_e = e;
        round_f = f_raw;
        if (fifth) begin
            if (f_raw != 4'hF) begin
                round_f = f_raw + 4'd1;
            end else if (e != 3'd7) begin
                round_f = 4'b1000;
                round_e = e + 3'd1;
            end else begin
                round_f = 4'hF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            d_r           <= '0;
            m             <= '0;
            e             <= '0;
            f_raw         <= '0;
            fifth         <= 1'b0;
            sign_r        <= 1'b0;
            bus.S         <= 1'b0;
            bus.E         <= '0;
            bus.F         <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        d_r          <= bus.D;
                        state        <= MAG;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                MAG: begin
                    sign_r <= d_r[11];
                    if (SKIP_ZERO && (abs_d == 12'd0)) begin
                        m     <= '0;
                        e     <= 3'd0;
                        f_raw <= 4'd0;
                        fifth <= 1'b0;
                        state <= ROUND;
                    end else begin
                        m     <= abs_d;
                        e     <= 3'd7;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (!m[10] && (e != 3'd0)) begin
                        m <= m << 1;
                        e <= e - 3'd1;
                    end else begin
                        f_raw <= m[10:7];
                        fifth <= m[6];
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    bus.S         <= sign_r;
                    bus.E         <= round_e;
                    bus.F         <= round_f;
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

`ifdef FPCVT_STATS_EN
    logic clamp_r;
    logic sat_r;

    // A result counts as saturated if rounding overflowed at e=7 or the input was the clamped 0x800.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clamp_r  <= 1'b0;
            sat_r    <= 1'b0;
            conv_cnt <= '0;
            sat_cnt  <= '0;
        end else begin
            if (state == MAG) begin
                clamp_r <= (d_r == 12'h800);
            end
            if (state == ROUND) begin
                sat_r <= clamp_r || (fifth && (f_raw == 4'hF) && (e == 3'd7));
            end
            if ((state == DONE) && bus.out_ready) begin
                conv_cnt <= conv_cnt + 8'd1;
                if (sat_r && (sat_cnt != 8'hFF)) begin
                    sat_cnt <= sat_cnt + 8'd1;
                end
            end
        end
    end
`endif

endmodule
